// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and the
// sigma/Sigma/Ch/Maj helpers used by the round datapath and the sequencer.
package sha256_pkg;

    typedef logic [31:0] word_t;

    // Word a sits in the most significant position, matching digest byte order.
    typedef struct packed {
        word_t a;
        word_t b;
        word_t c;
        word_t d;
        word_t e;
        word_t f;
        word_t g;
        word_t h;
    } state_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ROUND,
        ACCUM,
        DONE
    } fsm_t;

    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One SHA-256 compression round: working variables plus W[t] and K[t] in,
// next working variables out. Purely combinational.
module sha256_round
    import sha256_pkg::*;
(
    input  state_t work,
    input  word_t  w,
    input  word_t  k,
    output state_t result
);

    word_t t1;
    word_t t2;

    assign t1 = work.h + big_sigma1(work.e) + ch(work.e, work.f, work.g) + k + w;
    assign t2 = big_sigma0(work.a) + maj(work.a, work.b, work.c);

    assign result = {t1 + t2, work.a, work.b, work.c, work.d + t1, work.e, work.f, work.g};

endmodule

// File: rtl/sha256_header_seq.sv
// Hashes an 80-byte block header with SHA-256, one round per cycle.
// Defining SHA256_DOUBLE_HASH_EN adds a third pass so the digest is SHA-256(SHA-256(header)).
module sha256_header_seq
    import sha256_pkg::*;
#(
    parameter logic [255:0] H0 = IV
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [639:0] header,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic         busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; the producer holds valid and data steady until that edge.

`ifdef SHA256_DOUBLE_HASH_EN
    localparam logic [1:0] LAST_BLK = 2'd2;
`else
    localparam logic [1:0] LAST_BLK = 2'd1;
`endif

    fsm_t         state;
    logic [639:0] header_q;
    logic [1:0]   blk;
    logic [5:0]   rnd;
    word_t        win [16];
    state_t       work;
    logic [255:0] chain;

    state_t       round_out;
    word_t        w_next;
    logic [511:0] block;
    logic [255:0] work_v;
    logic [255:0] sum;
    logic         fresh;

    sha256_round u_round (
        .work   (work),
        .w      (win[0]),
        .k      (K[rnd]),
        .result (round_out)
    );

    // win[j] holds W[t+j] during round t, so the new tail word is W[t+16].
    assign w_next = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0];
    assign work_v = work;

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[32*i +: 32] = chain[32*i +: 32] + work_v[32*i +: 32];
        end
    end

    always_comb begin
        block = header_q[639:128];
        if (blk == 2'd1) begin
            block = {header_q[127:0], 8'h80, 312'd0, 64'd640};
        end
`ifdef SHA256_DOUBLE_HASH_EN
        else if (blk == 2'd2) begin
            // chain holds the first digest until this LOAD restarts it from H0
            block = {chain, 8'h80, 184'd0, 64'd256};
        end
`endif
    end

`ifdef SHA256_DOUBLE_HASH_EN
    assign fresh = (blk != 2'd1);
`else
    assign fresh = (blk == 2'd0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            start_ready  <= 1'b1;
            digest_valid <= 1'b0;
            digest       <= '0;
            busy         <= 1'b0;
            rnd          <= 6'd0;
            blk          <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        header_q    <= header;
                        blk         <= 2'd0;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < 16; i++) begin
                        win[i] <= block[511 - 32*i -: 32];
                    end
                    work <= fresh ? H0 : chain;
                    if (fresh) begin
                        chain <= H0;
                    end
                    rnd   <= 6'd0;
                    state <= ROUND;
                end
                ROUND: begin
                    work <= round_out;
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i+1];
                    end
                    win[15] <= w_next;
                    rnd     <= rnd + 6'd1;
                    if (rnd == 6'd63) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (blk == LAST_BLK) begin
                        digest       <= sum;
                        digest_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        chain <= sum;
                        blk   <= blk + 2'd1;
                        state <= LOAD;
                    end
                end
                DONE: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        start_ready  <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
